// File: rtl/shared_slot_arbiter.sv
// shared_slot_arbiter: single-owner grant of a shared resource, round-robin over slots 0..N-2, fixed priority for slot N-1, hold-time watchdog
module shared_slot_arbiter #(
  parameter int N        = 9,
  parameter int MAX_HOLD = 255,
  parameter int CNT_W    = 8
) (
  input  logic         clk40,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         gnt_valid,
  output logic [3:0]   gnt_id,
  output logic         timeout,
  output logic [3:0]   timeout_id
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       rr_ptr, rr_win, idx, winner;
  logic [4:0]       sum;
  logic [N-1:0]     lockout, elig;
  logic             rr_hit, rel, trip;
  assign elig   = req & ~lockout;
  assign winner = elig[N-1] ? 4'(N-1) : rr_win;
  assign rel    = !req[gnt_id];
  assign trip   = (MAX_HOLD != 0) && (cnt == CNT_W'(MAX_HOLD)) && req[gnt_id];
  // first eligible ordinary slot after rr_ptr, wrapping from N-2 back to 0
  always_comb begin
    rr_hit = 1'b0;
    rr_win = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 1; k < N; k++) begin
      sum = {1'b0, rr_ptr} + 5'(k);
      idx = (sum >= 5'(N-1)) ? 4'(sum - 5'(N-1)) : sum[3:0];
      if (!rr_hit && elig[idx]) begin
        rr_hit = 1'b1;
        rr_win = idx;
      end
    end
  end
  // grant FSM with registered outputs, hold counter, watchdog and lockout mask
  always_ff @(posedge clk40 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt        <= '0;
      gnt_valid  <= 1'b0;
      gnt_id     <= '0;
      timeout    <= 1'b0;
      timeout_id <= '0;
      cnt        <= '0;
      rr_ptr     <= 4'(N-2);
      lockout    <= '0;
    end else begin
      lockout <= lockout & req;
      timeout <= 1'b0;
      if (state == IDLE) begin
        if (|elig) begin
          state     <= GRANT;
          gnt       <= N'(1) << winner;
          gnt_valid <= 1'b1;
          gnt_id    <= winner;
          cnt       <= CNT_W'(1);
          if (!elig[N-1]) rr_ptr <= winner;
        end
      end else if (rel || trip) begin
        state     <= IDLE;
        gnt       <= '0;
        gnt_valid <= 1'b0;
        gnt_id    <= '0;
        cnt       <= '0;
        if (!rel) begin
          timeout         <= 1'b1;
          timeout_id      <= gnt_id;
          lockout[gnt_id] <= 1'b1;
        end
      end else begin
        cnt <= (&cnt) ? cnt : cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_shared_slot_arbiter.sv
// tb_shared_slot_arbiter: vector table, directed sequences and randomized run against a reference model
module tb_shared_slot_arbiter;
  localparam int N  = 9;
  localparam int MH = 4;
  logic         clk40 = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] gnt;
  logic         gnt_valid, timeout;
  logic [3:0]   gnt_id, timeout_id;
  int           checks = 0;
  int           failures = 0;
  always #12 clk40 = ~clk40;
  shared_slot_arbiter #(.N(N), .MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk40(clk40), .rst_n(rst_n), .req(req), .gnt(gnt), .gnt_valid(gnt_valid),
    .gnt_id(gnt_id), .timeout(timeout), .timeout_id(timeout_id)
  );
  typedef struct {
    logic [N-1:0] r;
    logic [N-1:0] g;
    logic         to;
    logic [3:0]   tid;
  } vec_t;
  vec_t tbl[$];
  int           m_owner, m_hold, m_last;
  logic [N-1:0] m_lock;
  logic         m_to;
  logic [3:0]   m_toid;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic chk_out(input string nm, input logic [N-1:0] g, input logic to, input logic [3:0] tid);
    chk({nm, " gnt"}, 32'(gnt), 32'(g));
    chk({nm, " gnt_valid"}, 32'(gnt_valid), 32'(|g));
    chk({nm, " gnt_id"}, 32'(gnt_id), (g == '0) ? 32'd0 : 32'($clog2(g)));
    chk({nm, " timeout"}, 32'(timeout), 32'(to));
    chk({nm, " timeout_id"}, 32'(timeout_id), 32'(tid));
  endtask
  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    @(negedge clk40);
    @(negedge clk40);
    chk_out("reset", '0, 1'b0, 4'd0);
    rst_n = 1'b1;
  endtask
  function automatic void model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_last  = N - 2;
    m_lock  = '0;
    m_to    = 1'b0;
    m_toid  = '0;
  endfunction
  function automatic void model_step(input logic [N-1:0] r);
    logic [N-1:0] elig;
    elig   = r & ~m_lock;
    m_to   = 1'b0;
    m_lock = m_lock & r;
    if (m_owner < 0) begin
      if (elig != '0) begin
        if (elig[N-1]) m_owner = N - 1;
        else
          for (int k = 1; k < N; k++) begin
            if (m_owner < 0 && elig[(m_last + k) % (N - 1)]) m_owner = (m_last + k) % (N - 1);
          end
        m_hold = 1;
        if (m_owner != N - 1) m_last = m_owner;
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (m_hold == MH) begin
      m_to           = 1'b1;
      m_toid         = 4'(m_owner);
      m_lock[m_owner] = 1'b1;
      m_owner        = -1;
    end else begin
      m_hold++;
    end
  endfunction
  function automatic logic [N-1:0] onehot(input int s);
    logic [N-1:0] one;
    one = 1;
    return (s < 0) ? '0 : one << s;
  endfunction
  initial begin
    tbl.push_back('{9'h004, 9'h004, 1'b0, 4'd0});
    tbl.push_back('{9'h004, 9'h004, 1'b0, 4'd0});
    tbl.push_back('{9'h000, 9'h000, 1'b0, 4'd0});
    tbl.push_back('{9'h000, 9'h000, 1'b0, 4'd0});
    tbl.push_back('{9'h003, 9'h001, 1'b0, 4'd0});
    tbl.push_back('{9'h003, 9'h001, 1'b0, 4'd0});
    tbl.push_back('{9'h002, 9'h000, 1'b0, 4'd0});
    tbl.push_back('{9'h002, 9'h002, 1'b0, 4'd0});
    tbl.push_back('{9'h102, 9'h002, 1'b0, 4'd0});
    tbl.push_back('{9'h100, 9'h000, 1'b0, 4'd0});
    tbl.push_back('{9'h130, 9'h100, 1'b0, 4'd0});
    tbl.push_back('{9'h030, 9'h000, 1'b0, 4'd0});
    tbl.push_back('{9'h030, 9'h010, 1'b0, 4'd0});
    tbl.push_back('{9'h010, 9'h010, 1'b0, 4'd0});
    tbl.push_back('{9'h010, 9'h010, 1'b0, 4'd0});
    tbl.push_back('{9'h010, 9'h010, 1'b0, 4'd0});
    tbl.push_back('{9'h010, 9'h000, 1'b1, 4'd4});
    tbl.push_back('{9'h010, 9'h000, 1'b0, 4'd4});
    tbl.push_back('{9'h010, 9'h000, 1'b0, 4'd4});
    tbl.push_back('{9'h000, 9'h000, 1'b0, 4'd4});
    tbl.push_back('{9'h010, 9'h010, 1'b0, 4'd4});
    tbl.push_back('{9'h010, 9'h010, 1'b0, 4'd4});
    tbl.push_back('{9'h010, 9'h010, 1'b0, 4'd4});
    tbl.push_back('{9'h010, 9'h010, 1'b0, 4'd4});
    tbl.push_back('{9'h000, 9'h000, 1'b0, 4'd4});
    tbl.push_back('{9'h010, 9'h010, 1'b0, 4'd4});
    tbl.push_back('{9'h000, 9'h000, 1'b0, 4'd4});
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].r;
      @(negedge clk40);
      chk_out($sformatf("vec%0d", i), tbl[i].g, tbl[i].to, tbl[i].tid);
    end
    do_reset();
    req = 9'h0FF;
    @(negedge clk40);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("rr owner %0d", i), 32'(gnt), 32'(onehot(i % 8)));
      repeat (2) @(negedge clk40);
      chk($sformatf("rr hold %0d", i), 32'(gnt), 32'(onehot(i % 8)));
      req = 9'h0FF & ~onehot(i % 8);
      @(negedge clk40);
      chk($sformatf("rr gap %0d", i), 32'(gnt), 32'd0);
      req = 9'h0FF;
      @(negedge clk40);
    end
    do_reset();
    req = 9'h080;
    @(negedge clk40);
    chk("midrst owner", 32'(gnt), 32'h080);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst gnt async", 32'(gnt), 32'd0);
    chk("midrst valid async", 32'(gnt_valid), 32'd0);
    @(negedge clk40);
    req   = 9'h0FF;
    rst_n = 1'b1;
    @(negedge clk40);
    chk("midrst first after", 32'(gnt), 32'h001);
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      chk_out($sformatf("rand%0d", c), onehot(m_owner), m_to, m_toid);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
      model_step(req);
      @(negedge clk40);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shared_slot_arbiter.md
# shared_slot_arbiter

Grants exclusive use of one shared resource to one of N per-slot instances of a generated slot array at a time, all clocked by clk40. Slots 0..N-2 are ordinary slots and are served round-robin. Slot N-1 is the special slot, which has fixed priority over all others. A hold-time watchdog revokes a grant that is held too long, and the block reports which slot was revoked.

## Interface
- N, default 9: number of requesting slots; slot N-1 is the special slot; legal range 3..16.
- MAX_HOLD, default 255: maximum grant length in cycles; 0 disables the watchdog.
- CNT_W, default 8: width of the hold counter; must satisfy MAX_HOLD < 2^CNT_W.
- clk40, in, 1: the only clock; all logic is on its rising edge.
- rst_n, in, 1: asynchronous reset, active low.
- req, in, N: per-slot request; a slot holds it high for the whole time it uses the resource.
- gnt, out, N: one-hot grant, or all zeros.
- gnt_valid, out, 1: OR-reduction of gnt, driven from a register.
- gnt_id, out, 4: index of the granted slot; 0 when gnt_valid=0.
- timeout, out, 1: one-cycle pulse when the watchdog revokes a grant.
- timeout_id, out, 4: index of the revoked slot; holds its value until the next timeout.

## Operation
- States: IDLE, GRANT.
- Reset values:
  - state = IDLE.
  - gnt = 0, gnt_valid = 0, gnt_id = 0.
  - timeout = 0, timeout_id = 0.
  - hold counter = 0.
  - round-robin pointer rr_ptr = N-2, so slot 0 is served first.
  - lockout mask = 0.
- Eligible slots: elig = req & ~lockout.
- IDLE:
  - If elig is zero, remain in IDLE.
  - Otherwise pick a winner:
    - elig[N-1] set: winner = N-1.
    - Otherwise: the first set bit of elig[N-2:0], searching upward from rr_ptr+1 and wrapping from N-2 to 0.
  - Register gnt / gnt_id for the winner and go to GRANT. Set the counter to 1.
  - When the winner is not N-1, set rr_ptr = winner. A grant to slot N-1 leaves rr_ptr unchanged.
- GRANT:
  - The owner keeps the grant while req[owner]=1. Each cycle the counter increments, saturating at 2^CNT_W-1.
  - Release: req[owner]=0 → next cycle gnt = 0 and state = IDLE.
  - Watchdog (MAX_HOLD > 0):
    - Trigger: counter == MAX_HOLD and req[owner]=1.
    - Next cycle: gnt = 0, timeout = 1, timeout_id = owner, lockout[owner] = 1, state = IDLE.
  - If release and watchdog trigger happen in the same cycle, treat it as a normal release with no timeout.
  - Requests from other slots, including slot N-1, never preempt a current grant.
- Lockout:
  - lockout[i] clears on the first cycle req[i] is sampled low.
  - A revoked slot must drop req for at least one cycle before it is eligible again.
- Only one grant is outstanding at any time; gnt is never more than one-hot.
- Request bits of slots that are not the owner have no effect in GRANT.

## Timing
- Request to grant: req sampled high at edge t while IDLE → gnt high after edge t+1, i.e. one cycle of latency.
- Release to next grant: owner's req sampled low at edge t → gnt low after t+1; a new winner's gnt is high after t+2. This guarantees at least one all-zero gnt cycle between owners.
- Maximum grant length: exactly MAX_HOLD cycles of gnt high; gnt falls on the cycle after the counter reaches MAX_HOLD.
- timeout rises on the same cycle gnt falls and lasts one cycle.
- Asynchronous reset mid-grant: gnt, gnt_valid and timeout drop immediately and the lockout mask clears. After rst_n deasserts, the first grant appears no earlier than edge 2.
- All outputs are registered; there are no combinational paths from req to gnt.

## Test plan
- Reset and single request: hold rst_n low, then release it; raise req=9'h004 → gnt=9'h004 and gnt_id=2 one cycle later. Drop req → gnt=0 one cycle later.
- Round-robin: hold req=9'h0FF continuously with each owner releasing after 3 cycles → grant order 0,1,...,7,0. Every handover shows one cycle of gnt=0.
- Special priority without preemption: slot 3 owns the grant and req[8] rises → slot 3 keeps the grant until it releases. Then slot 8 is granted ahead of pending slots 4 and 5. Afterwards rr_ptr=3, so slot 4 is served next.
- Watchdog with MAX_HOLD=4: slot 5 holds req high → exactly 4 cycles of gnt=9'h020, then timeout=1 for one cycle with timeout_id=5. Slot 5 is ignored while req stays high; it is granted again after req toggles low then high.
- Release on the boundary (MAX_HOLD=4): drop req on the cycle the counter equals 4 → timeout stays 0 and the slot is not locked out.
- Reset mid-grant: assert rst_n low while slot 7 owns the grant → gnt=0 asynchronously. After reset, with req=9'h0FF, slot 0 is granted first.
